// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types for the RV32I multi-cycle sequencer:
// states, opcode classes, immediate kinds and mux selects.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_SB   = 3'd3,
    IMM_UJ   = 3'd4,
    IMM_U    = 3'd5
  } imm_type_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  typedef enum logic [3:0] {
    CL_LUI,
    CL_AUIPC,
    CL_JAL,
    CL_JALR,
    CL_BRANCH,
    CL_LOAD,
    CL_STORE,
    CL_OPIMM,
    CL_OP,
    CL_ILL
  } op_class_t;

  typedef struct packed {
    op_class_t cls;
    imm_type_t imm;
    logic      src_imm;
    logic      a_pc;
    logic      legal;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_decoder.sv
// Opcode classifier: class, immediate kind,
// ALU operand selects and legality.
module multicycle_ctrl_fsm_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [6:0] i_opcode,
  output dec_t       o_dec
);

  // SYSTEM and anything unlisted fall through as illegal
  always_comb begin
    o_dec = '{CL_ILL, IMM_NONE, 1'b0, 1'b0, 1'b0};
    unique case (1'b1)
      (i_opcode == OPC_LUI):
        o_dec = '{CL_LUI, IMM_U, 1'b1, 1'b0, 1'b1};
      (i_opcode == OPC_AUIPC):
        o_dec = '{CL_AUIPC, IMM_U, 1'b1, 1'b1, 1'b1};
      (i_opcode == OPC_JAL):
        o_dec = '{CL_JAL, IMM_UJ, 1'b1, 1'b1, 1'b1};
      (i_opcode == OPC_JALR):
        o_dec = '{CL_JALR, IMM_I, 1'b1, 1'b0, 1'b1};
      (i_opcode == OPC_BRANCH):
        o_dec = '{CL_BRANCH, IMM_SB, 1'b0, 1'b1, 1'b1};
      (i_opcode == OPC_LOAD):
        o_dec = '{CL_LOAD, IMM_I, 1'b1, 1'b0, 1'b1};
      (i_opcode == OPC_STORE):
        o_dec = '{CL_STORE, IMM_S, 1'b1, 1'b0, 1'b1};
      (i_opcode == OPC_OPIMM):
        o_dec = '{CL_OPIMM, IMM_I, 1'b1, 1'b0, 1'b1};
      (i_opcode == OPC_OP):
        o_dec = '{CL_OP, IMM_NONE, 1'b0, 1'b0, 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB,
// instruction register and sticky illegal flag.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter logic [31:0] RESET_IR    = 32'h0000_0013,
  parameter bit          SUPPRESS_X0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        dmem_read_o,
  output logic        dmem_write_o,
  input  logic        dmem_ack_i,
  input  logic        branch_taken_i,
  output logic [31:0] ir_o,
  output logic [2:0]  imm_type_o,
  output logic        alu_src_imm_o,
  output logic        alu_a_pc_o,
  output logic        pc_en_o,
  output logic [1:0]  pc_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o,
  output logic [2:0]  state_o
);

  state_t      r_state;
  logic [31:0] r_ir;
  logic        r_illegal;
  dec_t        w_dec;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_active;

  multicycle_ctrl_fsm_decoder u_dec (
    .i_opcode (r_ir[6:0]),
    .o_dec    (w_dec)
  );

  assign w_is_ld   = (w_dec.cls == CL_LOAD);
  assign w_is_st   = (w_dec.cls == CL_STORE);
  assign w_is_jal  = (w_dec.cls == CL_JAL);
  assign w_is_jalr = (w_dec.cls == CL_JALR);
  assign w_active  = (r_state == S_DECODE) ||
                     (r_state == S_EXEC) ||
                     (r_state == S_MEM) ||
                     (r_state == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ir      <= RESET_IR;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:
          if (!halt_i && imem_ack_i) begin
            r_ir    <= imem_rdata_i;
            r_state <= S_DECODE;
          end
        S_DECODE:
          if (!w_dec.legal) begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        S_EXEC:
          unique case (1'b1)
            (w_dec.cls == CL_BRANCH): r_state <= S_FETCH;
            (w_is_ld || w_is_st):     r_state <= S_MEM;
            default:                  r_state <= S_WB;
          endcase
        S_MEM:
          if (dmem_ack_i)
            r_state <= w_is_ld ? S_WB : S_FETCH;
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Selects follow (state, IR); strobes are squashed while rst is high
  always_comb begin
    imem_req_o    = 1'b0;
    dmem_read_o   = 1'b0;
    dmem_write_o  = 1'b0;
    pc_en_o       = 1'b0;
    pc_sel_o      = PC_PLUS4;
    rf_we_o       = 1'b0;
    imm_type_o    = IMM_NONE;
    alu_src_imm_o = 1'b0;
    alu_a_pc_o    = 1'b0;
    wb_sel_o      = WB_ALU;
    if (w_active) begin
      imm_type_o    = w_dec.imm;
      alu_src_imm_o = w_dec.src_imm;
      alu_a_pc_o    = w_dec.a_pc;
      if (w_is_ld)
        wb_sel_o = WB_LOAD;
      else if (w_is_jal || w_is_jalr)
        wb_sel_o = WB_PC4;
    end
    if (!rst) begin
      case (r_state)
        S_FETCH: imem_req_o = !halt_i;
        S_EXEC:
          if (w_dec.cls == CL_BRANCH) begin
            pc_en_o  = 1'b1;
            pc_sel_o = branch_taken_i ? PC_IMM : PC_PLUS4;
          end
        S_MEM: begin
          dmem_read_o  = w_is_ld;
          dmem_write_o = w_is_st;
          pc_en_o      = w_is_st && dmem_ack_i;
        end
        S_WB: begin
          rf_we_o = !(SUPPRESS_X0 && (r_ir[11:7] == 5'd0));
          pc_en_o = 1'b1;
          if (w_is_jal)
            pc_sel_o = PC_IMM;
          else if (w_is_jalr)
            pc_sel_o = PC_JALR;
        end
        default: ;
      endcase
    end
  end

  assign ir_o      = r_ir;
  assign illegal_o = r_illegal;
  assign state_o   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed cycle-by-cycle bench for multicycle_ctrl_fsm:
// per-cycle expected output vectors for each instruction class.
module tb_multicycle_ctrl_fsm;

  localparam logic [2:0] F = 3'd0;
  localparam logic [2:0] D = 3'd1;
  localparam logic [2:0] E = 3'd2;
  localparam logic [2:0] M = 3'd3;
  localparam logic [2:0] W = 3'd4;
  localparam logic [2:0] T = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_i;
  logic        imem_req_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        dmem_read_o;
  logic        dmem_write_o;
  logic        dmem_ack_i;
  logic        branch_taken_i;
  logic [31:0] ir_o;
  logic [2:0]  imm_type_o;
  logic        alu_src_imm_o;
  logic        alu_a_pc_o;
  logic        pc_en_o;
  logic [1:0]  pc_sel_o;
  logic        rf_we_o;
  logic [1:0]  wb_sel_o;
  logic        illegal_o;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl_fsm dut (
    .clk            (clk),
    .rst            (rst),
    .halt_i         (halt_i),
    .imem_req_o     (imem_req_o),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i   (imem_rdata_i),
    .dmem_read_o    (dmem_read_o),
    .dmem_write_o   (dmem_write_o),
    .dmem_ack_i     (dmem_ack_i),
    .branch_taken_i (branch_taken_i),
    .ir_o           (ir_o),
    .imm_type_o     (imm_type_o),
    .alu_src_imm_o  (alu_src_imm_o),
    .alu_a_pc_o     (alu_a_pc_o),
    .pc_en_o        (pc_en_o),
    .pc_sel_o       (pc_sel_o),
    .rf_we_o        (rf_we_o),
    .wb_sel_o       (wb_sel_o),
    .illegal_o      (illegal_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {state_o, imm_type_o, alu_src_imm_o, alu_a_pc_o,
                     imem_req_o, dmem_read_o, dmem_write_o, pc_en_o,
                     pc_sel_o, rf_we_o, wb_sel_o, illegal_o};

  function automatic logic [17:0] ev(
    input logic [2:0] st, input logic [2:0] imm,
    input logic sim, input logic apc, input logic ireq,
    input logic drd, input logic dwr, input logic pce,
    input logic [1:0] pcs, input logic we,
    input logic [1:0] wbs, input logic ill);
    return {st, imm, sim, apc, ireq, drd, dwr, pce, pcs, we, wbs, ill};
  endfunction

  task automatic test_reset;
    #1;
    checks++;
    if (obs !== ev(F,0,0,0,0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_vec got %h exp %h", obs,
               ev(F,0,0,0,0,0,0,0,0,0,0,0));
    end
    checks++;
    if (ir_o !== 32'h0000_0013) begin
      errors++;
      $display("FAIL reset_ir got %h exp 00000013", ir_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== ev(F,0,0,0,1,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", obs,
               ev(F,0,0,0,1,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_addi;
    logic [17:0] e[5];
    e[0] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    e[1] = ev(D,1,1,0,0,0,0,0,0,0,0,0);
    e[2] = ev(E,1,1,0,0,0,0,0,0,0,0,0);
    e[3] = ev(W,1,1,0,0,0,0,1,0,1,0,0);
    e[4] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      imem_ack_i   = (i == 0);
      imem_rdata_i = 32'h0050_0093;
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL addi c%0d got %h exp %h", i, obs, e[i]);
      end
      if (i == 1) begin
        checks++;
        if (ir_o !== 32'h0050_0093) begin
          errors++;
          $display("FAIL addi_ir got %h exp 00500093", ir_o);
        end
      end
      @(posedge clk); #1;
    end
    imem_ack_i = 1'b0;
  endtask

  task automatic test_load;
    logic [17:0] e[9];
    e[0] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    e[1] = ev(D,1,1,0,0,0,0,0,0,0,1,0);
    e[2] = ev(E,1,1,0,0,0,0,0,0,0,1,0);
    e[3] = ev(M,1,1,0,0,1,0,0,0,0,1,0);
    e[4] = ev(M,1,1,0,0,1,0,0,0,0,1,0);
    e[5] = ev(M,1,1,0,0,1,0,0,0,0,1,0);
    e[6] = ev(M,1,1,0,0,1,0,0,0,0,1,0);
    e[7] = ev(W,1,1,0,0,0,0,1,0,1,1,0);
    e[8] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 9; i++) begin
      imem_ack_i   = (i == 0);
      imem_rdata_i = 32'h0080_A103;
      dmem_ack_i   = (i == 6);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL load c%0d got %h exp %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
  endtask

  task automatic test_branch;
    logic [17:0] e[4];
    for (int t = 1; t >= 0; t--) begin
      e[0] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
      e[1] = ev(D,3,0,1,0,0,0,0,0,0,0,0);
      e[2] = ev(E,3,0,1,0,0,0,1,(t == 1) ? 2'd1 : 2'd0,0,0,0);
      e[3] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
      for (int i = 0; i < 4; i++) begin
        imem_ack_i     = (i == 0);
        imem_rdata_i   = 32'h0000_0463;
        branch_taken_i = (t == 1);
        #1;
        checks++;
        if (obs !== e[i]) begin
          errors++;
          $display("FAIL branch t%0d c%0d got %h exp %h", t, i, obs, e[i]);
        end
        @(posedge clk); #1;
      end
    end
    imem_ack_i     = 1'b0;
    branch_taken_i = 1'b0;
  endtask

  task automatic test_jal;
    logic [17:0] e[5];
    e[0] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    e[1] = ev(D,4,1,1,0,0,0,0,0,0,2,0);
    e[2] = ev(E,4,1,1,0,0,0,0,0,0,2,0);
    e[3] = ev(W,4,1,1,0,0,0,1,1,0,2,0);
    e[4] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      imem_ack_i   = (i == 0);
      imem_rdata_i = 32'h0080_006F;
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL jal c%0d got %h exp %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
    imem_ack_i = 1'b0;
  endtask

  task automatic test_store;
    logic [17:0] e[5];
    e[0] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    e[1] = ev(D,2,1,0,0,0,0,0,0,0,0,0);
    e[2] = ev(E,2,1,0,0,0,0,0,0,0,0,0);
    e[3] = ev(M,2,1,0,0,0,1,1,0,0,0,0);
    e[4] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      imem_ack_i   = (i == 0);
      imem_rdata_i = 32'h0020_A223;
      dmem_ack_i   = (i == 3);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL store c%0d got %h exp %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
  endtask

  task automatic test_store_reset;
    logic [17:0] e[7];
    e[0] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    e[1] = ev(D,2,1,0,0,0,0,0,0,0,0,0);
    e[2] = ev(E,2,1,0,0,0,0,0,0,0,0,0);
    e[3] = ev(M,2,1,0,0,0,1,0,0,0,0,0);
    e[4] = ev(M,2,1,0,0,0,0,0,0,0,0,0);
    e[5] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    e[6] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 7; i++) begin
      imem_ack_i   = (i == 0);
      imem_rdata_i = 32'h0020_A223;
      rst          = (i == 4);
      dmem_ack_i   = (i == 5);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL store_rst c%0d got %h exp %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
    rst        = 1'b0;
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
  endtask

  task automatic test_trap;
    logic [17:0] e[6];
    e[0] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    e[1] = ev(D,0,0,0,0,0,0,0,0,0,0,0);
    e[2] = ev(T,0,0,0,0,0,0,0,0,0,0,1);
    e[3] = ev(T,0,0,0,0,0,0,0,0,0,0,1);
    e[4] = ev(T,0,0,0,0,0,0,0,0,0,0,1);
    e[5] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 6; i++) begin
      imem_ack_i   = (i == 0) || (i == 3);
      imem_rdata_i = (i == 0) ? 32'h0000_007F : 32'h0050_0093;
      dmem_ack_i   = (i == 3);
      rst          = (i == 4);
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL trap c%0d got %h exp %h", i, obs, e[i]);
      end
      if (i == 5) begin
        checks++;
        if (ir_o !== 32'h0000_0013) begin
          errors++;
          $display("FAIL trap_rst_ir got %h exp 00000013", ir_o);
        end
      end
      @(posedge clk); #1;
    end
    rst        = 1'b0;
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
  endtask

  task automatic test_halt;
    logic [17:0] e[3];
    e[0] = ev(F,0,0,0,0,0,0,0,0,0,0,0);
    e[1] = ev(F,0,0,0,0,0,0,0,0,0,0,0);
    e[2] = ev(F,0,0,0,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      halt_i       = (i < 2);
      imem_ack_i   = (i < 2);
      imem_rdata_i = 32'h0050_0093;
      #1;
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL halt c%0d got %h exp %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ir_o !== 32'h0000_0013) begin
      errors++;
      $display("FAIL halt_ir got %h exp 00000013", ir_o);
    end
    halt_i     = 1'b0;
    imem_ack_i = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    halt_i         = 1'b0;
    imem_ack_i     = 1'b0;
    imem_rdata_i   = 32'h0;
    dmem_ack_i     = 1'b0;
    branch_taken_i = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_jal();
    test_store();
    test_store_reset();
    test_trap();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
